// File: rtl/multi_interval_timer_pkg.sv
// Shared definitions for the multi-channel interval timer.
//   ch_state_e    : per-channel state (IDLE / RUN / DONE)
//   MODE_*        : encoding of the channel mode bit
//   sat_period()  : interval * unit multiplier, clipped to the counter range
package multi_interval_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } ch_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Product is formed at 64 bits so it cannot wrap before the clip.
    // count_w is expected to be at most 32.
    function automatic logic [31:0] sat_period(input logic [31:0] interval,
                                               input logic [31:0] mult,
                                               input int          count_w);
        logic [63:0] prod;
        logic [63:0] lim;
        prod = {32'd0, interval} * {32'd0, mult};
        lim  = (64'd1 << count_w) - 64'd1;
        return (prod > lim) ? lim[31:0] : prod[31:0];
    endfunction

endpackage

// File: rtl/multi_interval_timer_channel.sv
// One interval timer channel: period/mode registers, up-counter, state
// machine, registered warn and expire.
//   clock, reset   : system clock, async active-high reset
//   tick           : count strobe
//   cfg_we         : load period/mode from cfg_interval/cfg_oneshot
//   enable         : run enable (low pauses the channel)
//   restart        : synchronous restart keeping period and mode
//   count          : current count
//   running        : channel is in RUN
//   warn, expire   : pre-expiry window, one-cycle expiry pulse
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | not configured or period 0; count held at 0
// ST_RUN  | counting ticks while enabled
// ST_DONE | one-shot has expired; waits for restart/write
module interval_channel
    import multi_interval_timer_pkg::*;
#(
    parameter int INTERVAL_W = 16,
    parameter int COUNT_W    = 21,
    parameter int UNIT_MULT  = 60,
    parameter int WARN_LEAD  = 6
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  cfg_we,
    input  logic [INTERVAL_W-1:0] cfg_interval,
    input  logic                  cfg_oneshot,
    input  logic                  enable,
    input  logic                  restart,
    output logic [COUNT_W-1:0]    count,
    output logic                  running,
    output logic                  warn,
    output logic                  expire
);

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] LEAD    = COUNT_W'(WARN_LEAD);

    ch_state_e            state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [COUNT_W-1:0]   period_q, period_d;
    logic                 oneshot_q, oneshot_d;
    logic                 warn_q, warn_d;
    logic                 expire_q, expire_d;
    logic [COUNT_W-1:0]   p_new;

    assign p_new = COUNT_W'(sat_period(32'(cfg_interval), 32'(UNIT_MULT), COUNT_W));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            period_q  <= '0;
            oneshot_q <= MODE_PERIODIC;
            warn_q    <= 1'b0;
            expire_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            warn_q    <= warn_d;
            expire_q  <= expire_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        expire_d  = 1'b0;

        if (cfg_we) begin
            period_d  = p_new;
            oneshot_d = cfg_oneshot;
            count_d   = '0;
            state_d   = (enable && p_new != '0) ? ST_RUN : ST_IDLE;
        end else if (restart) begin
            count_d = '0;
            state_d = (period_q != '0) ? ST_RUN : ST_IDLE;
        end else if (tick && enable && state_q == ST_RUN) begin
            if (count_q == period_q - CNT_ONE) begin
                count_d  = '0;
                expire_d = 1'b1;
                if (oneshot_q == MODE_ONESHOT) begin
                    state_d = ST_DONE;
                end
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end

        // Evaluated on next-state values so warn lands on the same edge as
        // count; short periods (<= lead) keep warn up for all of RUN except
        // the expiry cycle.
        warn_d = (state_d == ST_RUN) && !expire_d
                 && ((period_d <= LEAD) || (count_d >= period_d - LEAD))
                 && (count_d <= period_d - CNT_ONE);
    end

    assign count   = count_q;
    assign running = (state_q == ST_RUN);
    assign warn    = warn_q;
    assign expire  = expire_q;

endmodule

// File: rtl/multi_interval_timer.sv
// Multi-channel interval timer: NUM_CH independent interval_channel
// instances sharing one tick, with a channel-addressed config write port
// and a combinational count readback mux.
//   clock, reset                         : system clock, async active-high reset
//   tick                                 : 1 Hz count strobe
//   cfg_we/cfg_ch/cfg_interval/cfg_oneshot : per-channel period/mode write
//   ch_enable, ch_restart                : per-channel run enable / restart
//   rd_ch, rd_count                      : count readback
//   running, warn, expire                : per-channel status
module multi_interval_timer
    import multi_interval_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int INTERVAL_W = 16,
    parameter int COUNT_W    = 21,
    parameter int UNIT_MULT  = 60,
    parameter int WARN_LEAD  = 6
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      cfg_we,
    input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
    input  logic [INTERVAL_W-1:0]     cfg_interval,
    input  logic                      cfg_oneshot,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         ch_restart,
    input  logic [$clog2(NUM_CH)-1:0] rd_ch,
    output logic [COUNT_W-1:0]        rd_count,
    output logic [NUM_CH-1:0]         running,
    output logic [NUM_CH-1:0]         warn,
    output logic [NUM_CH-1:0]         expire
);

    localparam int CH_W = $clog2(NUM_CH);

    logic [COUNT_W-1:0] counts [NUM_CH];
    logic [NUM_CH-1:0]  ch_we;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_we[i] = cfg_we && (cfg_ch == CH_W'(i));

        interval_channel #(
            .INTERVAL_W (INTERVAL_W),
            .COUNT_W    (COUNT_W),
            .UNIT_MULT  (UNIT_MULT),
            .WARN_LEAD  (WARN_LEAD)
        ) u_ch (
            .clock        (clock),
            .reset        (reset),
            .tick         (tick),
            .cfg_we       (ch_we[i]),
            .cfg_interval (cfg_interval),
            .cfg_oneshot  (cfg_oneshot),
            .enable       (ch_enable[i]),
            .restart      (ch_restart[i]),
            .count        (counts[i]),
            .running      (running[i]),
            .warn         (warn[i]),
            .expire       (expire[i])
        );
    end

    assign rd_count = counts[rd_ch];

endmodule

// File: tb/tb_multi_interval_timer.sv
module tb_multi_interval_timer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_ch = '0;
    logic [15:0] cfg_interval = '0;
    logic        cfg_oneshot = 1'b0;
    logic [3:0]  ch_enable = '0;
    logic [3:0]  ch_restart = '0;
    logic [1:0]  rd_ch = '0;
    logic [20:0] rd_count;
    logic [3:0]  running;
    logic [3:0]  warn;
    logic [3:0]  expire;

    multi_interval_timer dut (
        .clock        (clock),
        .reset        (reset),
        .tick         (tick),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_interval (cfg_interval),
        .cfg_oneshot  (cfg_oneshot),
        .ch_enable    (ch_enable),
        .ch_restart   (ch_restart),
        .rd_ch        (rd_ch),
        .rd_count     (rd_count),
        .running      (running),
        .warn         (warn),
        .expire       (expire)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int ticks_sent = 0;

    typedef struct packed {
        logic [7:0]  ch;
        logic [31:0] tno;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        step();
        ticks_sent++;
        tick = 1'b0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick_once();
    endtask

    task automatic write_cfg(input int ch, input int interval, input logic oneshot);
        cfg_we       = 1'b1;
        cfg_ch       = 2'(ch);
        cfg_interval = 16'(interval);
        cfg_oneshot  = oneshot;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic check_count(input string name, input int ch, input int want);
        rd_ch = 2'(ch);
        #1;
        chk(name, 32'(rd_count), 32'(want));
    endtask

    // Expected expiry of channel ch on the tick numbered ticks_sent+offset.
    task automatic expect_expire(input int ch, input int offset);
        exp_t e;
        e.ch  = 8'(ch);
        e.tno = 32'(ticks_sent + offset);
        exp_q.push_back(e);
    endtask

    // Monitor: every expire pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        for (int c = 0; c < 4; c++) begin
            if (expire[c]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_expire: ch %0d at tick %0d, none required", c, ticks_sent);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("expire_ch", 32'(c), 32'(e.ch));
                    chk("expire_tick", 32'(ticks_sent), e.tno);
                end
            end
        end
    end

    initial begin
        // reset state
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_running", 32'(running), 0);
        chk("rst_warn", 32'(warn), 0);
        chk("rst_expire", 32'(expire), 0);
        for (int c = 0; c < 4; c++) check_count("rst_count", c, 0);

        // ch0 periodic, interval 1 -> P=60
        ch_enable = 4'b0001;
        write_cfg(0, 1, 1'b0);
        chk("ch0_running", 32'(running[0]), 1);
        check_count("ch0_count_init", 0, 0);
        expect_expire(0, 60);
        expect_expire(0, 120);
        expect_expire(0, 180);
        for (int k = 1; k <= 180; k++) begin
            tick_once();
            check_count("ch0_count", 0, k % 60);
            chk("ch0_warn", 32'(warn[0]), 32'((k % 60) >= 54));
        end
        step();
        check_count("ch0_idle_cycle", 0, 0);

        // pause ch0 at 30 for 20 ticks
        tick_n(30);
        check_count("ch0_pre_pause", 0, 30);
        ch_enable[0] = 1'b0;
        tick_n(20);
        check_count("ch0_paused", 0, 30);
        chk("ch0_paused_running", 32'(running[0]), 1);
        ch_enable[0] = 1'b1;
        expect_expire(0, 30);
        tick_n(29);
        check_count("ch0_resumed", 0, 59);
        chk("ch0_warn_59", 32'(warn[0]), 1);
        tick_once();
        check_count("ch0_wrap", 0, 0);
        chk("ch0_warn_wrap", 32'(warn[0]), 0);
        ch_enable[0] = 1'b0;

        // ch1 one-shot, interval 2 -> P=120
        ch_enable[1] = 1'b1;
        write_cfg(1, 2, 1'b1);
        chk("ch1_running", 32'(running[1]), 1);
        expect_expire(1, 120);
        tick_n(60);
        check_count("ch1_mid", 1, 60);
        tick_n(60);
        chk("ch1_done_running", 32'(running[1]), 0);
        check_count("ch1_done_count", 1, 0);
        tick_n(5);
        check_count("ch1_done_hold", 1, 0);
        chk("ch1_done_hold_running", 32'(running[1]), 0);
        ch_restart = 4'b0010;
        step();
        ch_restart = 4'b0000;
        chk("ch1_restart_running", 32'(running[1]), 1);
        check_count("ch1_restart_count", 1, 0);
        expect_expire(1, 120);
        tick_n(120);
        chk("ch1_done2_running", 32'(running[1]), 0);

        // ch2: write + restart + tick in the same cycle
        ch_enable[2] = 1'b1;
        write_cfg(2, 1, 1'b0);
        tick_n(10);
        check_count("ch2_pre", 2, 10);
        cfg_we       = 1'b1;
        cfg_ch       = 2'd2;
        cfg_interval = 16'd2;
        cfg_oneshot  = 1'b0;
        ch_restart   = 4'b0100;
        tick         = 1'b1;
        step();
        ticks_sent++;
        cfg_we     = 1'b0;
        ch_restart = 4'b0000;
        tick       = 1'b0;
        check_count("ch2_collide_count", 2, 0);
        chk("ch2_collide_running", 32'(running[2]), 1);
        expect_expire(2, 120);
        tick_n(60);
        check_count("ch2_newp_mid", 2, 60);
        tick_n(60);
        check_count("ch2_newp_wrap", 2, 0);

        // interval 0 stays IDLE; 0xFFFF saturates
        write_cfg(2, 0, 1'b0);
        chk("ch2_zero_running", 32'(running[2]), 0);
        tick_n(3);
        check_count("ch2_zero_count", 2, 0);
        ch_enable[3] = 1'b1;
        write_cfg(3, 16'hFFFF, 1'b0);
        chk("ch3_sat_running", 32'(running[3]), 1);
        chk("ch3_sat_period", 32'(dut.g_ch[3].u_ch.period_q), 32'd2097151);
        tick_n(5);
        check_count("ch3_sat_count", 3, 5);
        chk("ch3_sat_warn", 32'(warn[3]), 0);

        // reset with ch3 at P-1 and a tick pending
        write_cfg(3, 1, 1'b0);
        tick_n(59);
        check_count("ch3_pre_reset", 3, 59);
        chk("ch3_pre_reset_warn", 32'(warn[3]), 1);
        tick = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_running", 32'(running), 0);
        chk("async_rst_warn", 32'(warn), 0);
        chk("async_rst_expire", 32'(expire), 0);
        chk("async_rst_count", 32'(rd_count), 0);
        step();
        chk("rst_edge_expire", 32'(expire), 0);
        chk("rst_edge_running", 32'(running), 0);
        tick  = 1'b0;
        reset = 1'b0;
        step();
        chk("post_rst_running", 32'(running), 0);
        chk("post_rst_warn", 32'(warn), 0);
        for (int c = 0; c < 4; c++) check_count("post_rst_count", c, 0);
        step();

        chk("pending_expires", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
